// File: rtl/fetch_sequencer_pkg.sv
// Shared types and defaults for the instruction fetch sequencer.
// Optional retired-fetch counter is enabled by defining FETCH_PERF_EN.
package fetch_sequencer_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } fetch_state_t;

  localparam int unsigned DEFAULT_A          = 12;
  localparam int unsigned DEFAULT_START_ADDR = 0;
  localparam int unsigned COUNT_W            = 32;

endpackage

// File: rtl/fetch_sequencer_if.sv
// Control/ROM-address bundle between top-level control and the fetch sequencer.
// InstCount exists only when FETCH_PERF_EN is defined.
interface fetch_sequencer_if
  import fetch_sequencer_pkg::*;
#(
  parameter int unsigned A = DEFAULT_A
);

  logic           Start;
  logic           Stall;
  logic           BranchEn;
  logic           BranchRel;
  logic [A-1:0]   BranchTarget;
  logic           HaltReq;
  logic [A-1:0]   InstAddress;
  logic           InstValid;
  logic           Done;
`ifdef FETCH_PERF_EN
  logic [COUNT_W-1:0] InstCount;
`endif

  modport master (
    output Start,
    output Stall,
    output BranchEn,
    output BranchRel,
    output BranchTarget,
    output HaltReq,
    input  InstAddress,
    input  InstValid,
`ifdef FETCH_PERF_EN
    input  InstCount,
`endif
    input  Done
  );

  modport slave (
    input  Start,
    input  Stall,
    input  BranchEn,
    input  BranchRel,
    input  BranchTarget,
    input  HaltReq,
    output InstAddress,
    output InstValid,
`ifdef FETCH_PERF_EN
    output InstCount,
`endif
    output Done
  );

endinterface

// File: rtl/fetch_sequencer_pc_next.sv
// Combinational next-PC selection: halt > stall > branch (abs/rel) > increment, all mod 2**A.
module fetch_sequencer_pc_next #(
  parameter int unsigned A = 12
) (
  input  logic [A-1:0] pc,
  input  logic         halt,
  input  logic         stall,
  input  logic         branch_en,
  input  logic         branch_rel,
  input  logic [A-1:0] branch_target,
  output logic [A-1:0] next_pc_c,
  output logic         advance_c
);

  // Relative offset is two's complement, so a plain A-bit add gives the signed wrap.
  always_comb begin
    next_pc_c = pc;
    advance_c = 1'b0;
    if (!halt && !stall) begin
      advance_c = 1'b1;
      if (branch_en) begin
        if (branch_rel) begin
          next_pc_c = pc + branch_target;
        end else begin
          next_pc_c = branch_target;
        end
      end else begin
        next_pc_c = pc + A'(1);
      end
    end
  end

endmodule

// File: rtl/fetch_sequencer.sv
// Program-counter controller driving the instruction ROM address from a Start/Done handshake.
// Define FETCH_PERF_EN to add the saturating retired-fetch counter (InstCount).
module fetch_sequencer
  import fetch_sequencer_pkg::*;
#(
  parameter int unsigned A          = DEFAULT_A,
  parameter int unsigned START_ADDR = DEFAULT_START_ADDR
) (
  input  logic              Clk,
  input  logic              Reset,
  fetch_sequencer_if.slave  bus
);

  localparam logic [1:0]   S_IDLE   = IDLE;
  localparam logic [1:0]   S_RUN    = RUN;
  localparam logic [1:0]   S_DONE   = DONE;
  localparam logic [A-1:0] PC_START = A'(START_ADDR);

  logic [1:0]   state_q, state_d;
  logic [A-1:0] pc_q, pc_d;
  logic         valid_q, valid_d;
  logic         done_q, done_d;
  logic [A-1:0] next_pc_c;
  logic         advance_c;
`ifdef FETCH_PERF_EN
  logic [COUNT_W-1:0] count_q, count_d;
`endif

  fetch_sequencer_pc_next #(
    .A (A)
  ) u_pc_next (
    .pc            (pc_q),
    .halt          (bus.HaltReq),
    .stall         (bus.Stall),
    .branch_en     (bus.BranchEn),
    .branch_rel    (bus.BranchRel),
    .branch_target (bus.BranchTarget),
    .next_pc_c     (next_pc_c),
    .advance_c     (advance_c)
  );

  // Next-state, PC and status; datapath controls only matter while running.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    valid_d = valid_q;
    done_d  = done_q;
`ifdef FETCH_PERF_EN
    count_d = count_q;
`endif
    case (state_q)
      S_IDLE, S_DONE: begin
        if (bus.Start) begin
          state_d = S_RUN;
          pc_d    = PC_START;
          valid_d = 1'b1;
          done_d  = 1'b0;
`ifdef FETCH_PERF_EN
          count_d = '0;
`endif
        end
      end
      S_RUN: begin
        pc_d = next_pc_c;
        if (bus.HaltReq) begin
          state_d = S_DONE;
          valid_d = 1'b0;
          done_d  = 1'b1;
        end
`ifdef FETCH_PERF_EN
        if (advance_c && (count_q != '1)) begin
          count_d = count_q + COUNT_W'(1);
        end
`endif
      end
      default: begin
        state_d = S_IDLE;
        pc_d    = PC_START;
        valid_d = 1'b0;
        done_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= S_IDLE;
      pc_q    <= PC_START;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      valid_q <= valid_d;
      done_q  <= done_d;
    end
  end

`ifdef FETCH_PERF_EN
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign bus.InstCount = count_q;
`endif

  assign bus.InstAddress = pc_q;
  assign bus.InstValid   = valid_q;
  assign bus.Done        = done_q;

endmodule
